// File: rtl/pif_regctl.sv
// pif_regctl: command decoder and 6-bit register bank behind the I2C slave
// byte interface. It decodes tagged host bytes (address / data), keeps a
// register pointer across transactions and serves read bytes back to the
// slave. Register 0 is a read-only ID and register 2 drives the LED mode.
module pif_regctl #(
  parameter int          NREGS   = 8,
  parameter logic [5:0]  ID_VAL  = 6'h2A,
  parameter logic [5:0]  LED_RST = 6'd0
) (
  input  logic                 CLK,
  input  logic                 GSRn,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_start,
  input  logic                 rx_stop,
  input  logic                 tx_req,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [6*NREGS-1:0]   regs_flat,
  output logic [5:0]           led_mode,
  output logic                 wr_pulse,
  output logic [7:0]           err_cnt
);

  // Byte tags shared with the slave side (pifdefs.v values).
  localparam logic [1:0] A_ADDR = 2'b01;
  localparam logic [1:0] D_ADDR = 2'b10;

  localparam int         IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [6:0] NREGS_LIM = 7'(NREGS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  ptr, ptr_dec, ptr_nxt;
  logic        ptr_valid;
  logic [5:0]  regs [NREGS];

  logic [1:0]  tag;
  logic [5:0]  payload;
  logic        decode_en, is_a, is_d, is_bad;
  logic        ptr_in_range, wr_en, err_inc;
  logic [7:0]  rd_byte;

  // Saturating increment for the malformed-byte counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tag     = rx_data[7:6];
  assign payload = rx_data[5:0];

  // Session FSM: bytes are only decoded between START and STOP.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic for the session FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_start) state_nxt = ACTIVE;
      ACTIVE:  if (rx_stop)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte classification, write qualification and pointer update.
  // An address load wins over the read increment; a data byte advances
  // the pointer and a concurrent read advances it once more.
  always_comb begin
    decode_en    = (state == ACTIVE) && rx_valid;
    is_a         = (tag == A_ADDR);
    is_d         = (tag == D_ADDR);
    is_bad       = !is_a && !is_d;
    ptr_in_range = ({1'b0, ptr} < NREGS_LIM);
    wr_en        = decode_en && is_d && ptr_valid && ptr_in_range && (ptr != 6'd0);
    err_inc      = decode_en && (is_bad || (is_d && !ptr_valid));
    rd_byte      = ptr_in_range ? {D_ADDR, regs[ptr[IDX_W-1:0]]} : 8'hFF;

    ptr_dec = ptr;
    if (decode_en && is_a)      ptr_dec = payload;
    else if (decode_en && is_d) ptr_dec = ptr + 6'd1;

    ptr_nxt = ptr_dec;
    if (tx_req && !(decode_en && is_a)) ptr_nxt = ptr_dec + 6'd1;
  end

  // Pointer, pointer-valid flag and error counter.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      ptr       <= 6'd0;
      ptr_valid <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      ptr <= ptr_nxt;
      if (decode_en && is_a) ptr_valid <= 1'b1;
      if (err_inc)           err_cnt   <= sat_inc(err_cnt);
    end
  end

  // Register bank; reg0 is only ever loaded with the ID at reset.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 6'd0;
      regs[0] <= ID_VAL;
      regs[2] <= LED_RST;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      if (wr_en) regs[ptr[IDX_W-1:0]] <= payload;
    end
  end

  // Read path: the byte is captured with the pre-cycle pointer and held.
  always_ff @(posedge CLK or negedge GSRn) begin
    if (!GSRn) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= tx_req;
      if (tx_req) tx_data <= rd_byte;
    end
  end

  // Flattened register view and LED mode tap.
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[6*i +: 6] = regs[i];
    led_mode = regs[2];
  end

endmodule

// File: tb/tb_pif_regctl.sv
// Testbench for pif_regctl: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the register bank.
module tb_pif_regctl;

  localparam int         NREGS   = 8;
  localparam logic [5:0] ID_VAL  = 6'h2A;
  localparam logic [5:0] LED_RST = 6'd0;
  localparam logic [1:0] A_T     = 2'b01;
  localparam logic [1:0] D_T     = 2'b10;

  logic                CLK = 1'b0;
  logic                GSRn = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0, rx_start = 1'b0, rx_stop = 1'b0, tx_req = 1'b0;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic [6*NREGS-1:0]  regs_flat;
  logic [5:0]          led_mode;
  logic                wr_pulse;
  logic [7:0]          err_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [5:0] m_regs [NREGS];
  int         m_ptr;
  bit         m_pv, m_active;
  int         m_err;
  logic [7:0] m_txd;
  bit         m_txv, m_wr;

  pif_regctl #(.NREGS(NREGS), .ID_VAL(ID_VAL), .LED_RST(LED_RST)) dut (
    .CLK(CLK), .GSRn(GSRn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_start(rx_start), .rx_stop(rx_stop), .tx_req(tx_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .regs_flat(regs_flat),
    .led_mode(led_mode), .wr_pulse(wr_pulse), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6*NREGS-1:0] model_flat();
    logic [6*NREGS-1:0] f;
    for (int i = 0; i < NREGS; i++) f[6*i +: 6] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 6'd0;
    m_regs[0] = ID_VAL;
    m_regs[2] = LED_RST;
    m_ptr = 0; m_pv = 0; m_active = 0; m_err = 0;
    m_txd = 8'h00; m_txv = 0; m_wr = 0;
  endtask

  // One clock of behaviour, computed from the byte-protocol rules.
  task automatic model_update(input bit v, input logic [7:0] d, input bit s, input bit p, input bit r);
    logic [7:0] rd;
    bit load;
    int pl;
    rd   = (m_ptr < NREGS) ? {D_T, m_regs[m_ptr]} : 8'hFF;
    load = 0;
    m_wr = 0;
    pl   = int'(d[5:0]);
    if (m_active && v) begin
      if (d[7:6] == A_T) begin
        m_ptr = pl; m_pv = 1; load = 1;
      end else if (d[7:6] == D_T) begin
        if (!m_pv) m_err = (m_err < 255) ? m_err + 1 : 255;
        else if (m_ptr < NREGS && m_ptr != 0) begin
          m_regs[m_ptr] = d[5:0]; m_wr = 1;
        end
        m_ptr = (m_ptr + 1) % 64;
      end else begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end
    end
    m_txv = r;
    if (r) begin
      m_txd = rd;
      if (!load) m_ptr = (m_ptr + 1) % 64;
    end
    if (!m_active && s) m_active = 1;
    else if (m_active && p) m_active = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample at negedge.
  task automatic step(input bit v, input logic [7:0] d, input bit s, input bit p, input bit r);
    rx_valid = v; rx_data = d; rx_start = s; rx_stop = p; tx_req = r;
    @(posedge CLK);
    model_update(v, d, s, p, r);
    @(negedge CLK);
    rx_valid = 0; rx_start = 0; rx_stop = 0; tx_req = 0;
  endtask

  task automatic do_reset();
    GSRn = 0;
    repeat (2) @(negedge CLK);
    model_reset();
    GSRn = 1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tx_valid !== 1'b0 || wr_pulse !== 1'b0 || err_cnt !== 8'h00 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctl: txv=%b wr=%b err=%h txd=%h required 0 0 00 00", tx_valid, wr_pulse, err_cnt, tx_data);
    end
    checks++;
    if (regs_flat !== model_flat() || led_mode !== 6'd0) begin
      failures++;
      $display("FAIL reset_regs: flat=%h led=%h required %h 00", regs_flat, led_mode, model_flat());
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== {D_T, 6'h2A}) begin
      failures++;
      $display("FAIL reset_read_id: txv=%b txd=%h required 1 %h", tx_valid, tx_data, {D_T, 6'h2A});
    end
    step(0, 8'h00, 0, 0, 0);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== {D_T, 6'h2A}) begin
      failures++;
      $display("FAIL tx_hold: txv=%b txd=%h required 0 %h", tx_valid, tx_data, {D_T, 6'h2A});
    end
  endtask

  task automatic test_led_write();
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    step(1, {A_T, 6'd3}, 0, 0, 0);
    step(1, {D_T, 6'd9}, 0, 0, 0);
    step(1, {A_T, 6'd2}, 0, 0, 0);
    step(1, {D_T, 6'd1}, 0, 0, 0);
    checks++;
    if (led_mode !== 6'd1 || wr_pulse !== 1'b1) begin
      failures++;
      $display("FAIL led_write: led=%0d wr=%b required 1 1", led_mode, wr_pulse);
    end
    step(0, 8'h00, 0, 1, 0);
    checks++;
    if (wr_pulse !== 1'b0) begin
      failures++;
      $display("FAIL wr_single_pulse: wr=%b required 0", wr_pulse);
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== {D_T, 6'd9}) begin
      failures++;
      $display("FAIL ptr_after_write: txd=%h required %h", tx_data, {D_T, 6'd9});
    end
  endtask

  task automatic test_auto_inc();
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    step(1, {A_T, 6'd6}, 0, 0, 0);
    step(1, {D_T, 6'd5}, 0, 0, 0);
    step(1, {D_T, 6'd6}, 0, 0, 0);
    step(1, {D_T, 6'd7}, 0, 0, 0);
    checks++;
    if (regs_flat[36 +: 6] !== 6'd5 || regs_flat[42 +: 6] !== 6'd6 || err_cnt !== 8'd0 || wr_pulse !== 1'b0) begin
      failures++;
      $display("FAIL auto_inc: r6=%0d r7=%0d err=%0d wr=%b required 5 6 0 0",
               regs_flat[36 +: 6], regs_flat[42 +: 6], err_cnt, wr_pulse);
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== 8'hFF || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL read_out_of_range: txd=%h txv=%b required ff 1", tx_data, tx_valid);
    end
  endtask

  task automatic test_errors();
    logic [6*NREGS-1:0] flat0;
    do_reset();
    flat0 = regs_flat;
    step(0, 8'h00, 1, 0, 0);
    step(1, {D_T, 6'd4}, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'hC0, 0, 0, 0);
    checks++;
    if (err_cnt !== 8'd3 || regs_flat !== flat0) begin
      failures++;
      $display("FAIL err_count3: err=%0d flat=%h required 3 %h", err_cnt, regs_flat, flat0);
    end
    for (int i = 0; i < 260; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      b[7] = b[6];
      step(1, b, 0, 0, 0);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL err_saturate: err=%h required ff", err_cnt);
    end
  endtask

  task automatic test_read();
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    step(1, {A_T, 6'd4}, 0, 0, 0);
    step(1, {D_T, 6'h22}, 0, 0, 0);
    step(1, {A_T, 6'd2}, 0, 0, 0);
    step(1, {D_T, 6'h15}, 0, 0, 0);
    step(1, {A_T, 6'd2}, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== {D_T, 6'h15} || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL read_reg2: txd=%h txv=%b required %h 1", tx_data, tx_valid, {D_T, 6'h15});
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== {D_T, 6'h00}) begin
      failures++;
      $display("FAIL read_reg3: txd=%h required %h", tx_data, {D_T, 6'h00});
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== {D_T, 6'h22}) begin
      failures++;
      $display("FAIL read_ptr4: txd=%h required %h", tx_data, {D_T, 6'h22});
    end
    step(1, {A_T, 6'd63}, 0, 0, 0);
    step(1, {D_T, 6'h11}, 0, 0, 0);
    checks++;
    if (wr_pulse !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL ptr63_drop: wr=%b err=%0d required 0 0", wr_pulse, err_cnt);
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== {D_T, ID_VAL}) begin
      failures++;
      $display("FAIL ptr_wrap: txd=%h required %h", tx_data, {D_T, ID_VAL});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    step(1, {A_T, 6'd4}, 0, 0, 0);
    step(1, {D_T, 6'h2C}, 0, 0, 0);
    step(1, {A_T, 6'd2}, 0, 0, 0);
    step(1, {D_T, 6'h07}, 0, 0, 0);
    step(1, {A_T, 6'd2}, 0, 0, 0);
    step(1, {D_T, 6'h03}, 0, 1, 1);
    checks++;
    if (tx_data !== {D_T, 6'h07} || led_mode !== 6'h03 || wr_pulse !== 1'b1) begin
      failures++;
      $display("FAIL rx_tx_same_cycle: txd=%h led=%h wr=%b required %h 03 1", tx_data, led_mode, wr_pulse, {D_T, 6'h07});
    end
    step(0, 8'h00, 0, 0, 1);
    checks++;
    if (tx_data !== {D_T, 6'h2C}) begin
      failures++;
      $display("FAIL rx_tx_ptr: txd=%h required %h", tx_data, {D_T, 6'h2C});
    end
    step(1, {D_T, 6'h01}, 0, 0, 0);
    checks++;
    if (wr_pulse !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_stop: wr=%b required 0", wr_pulse);
    end
  endtask

  task automatic test_gsr_mid();
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    step(1, {A_T, 6'd2}, 0, 0, 0);
    rx_valid = 1; rx_data = {D_T, 6'h3F}; tx_req = 1;
    @(posedge CLK);
    #1 GSRn = 0;
    rx_valid = 0; tx_req = 0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || wr_pulse !== 1'b0 || led_mode !== LED_RST || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL gsr_async: txv=%b wr=%b led=%h txd=%h required 0 0 %h 00", tx_valid, wr_pulse, led_mode, tx_data, LED_RST);
    end
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    checks++;
    if (tx_valid !== 1'b0 || regs_flat !== model_flat() || err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL gsr_hold: txv=%b flat=%h err=%h required 0 %h 00", tx_valid, regs_flat, err_cnt, model_flat());
    end
    GSRn = 1;
    @(negedge CLK);
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      bit v, s, p, r;
      logic [7:0] d;
      int k;
      v = ($urandom_range(0, 99) < 60);
      s = ($urandom_range(0, 99) < 8);
      p = ($urandom_range(0, 99) < 6);
      r = ($urandom_range(0, 99) < 30);
      k = $urandom_range(0, 9);
      d[7:6] = (k < 4) ? D_T : (k < 8) ? A_T : 2'($urandom);
      d[5:0] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
      step(v, d, s, p, r);
      checks++;
      if (tx_valid !== m_txv || tx_data !== m_txd || wr_pulse !== m_wr ||
          regs_flat !== model_flat() || led_mode !== m_regs[2] || err_cnt !== 8'(m_err)) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: txv=%b txd=%h wr=%b flat=%h err=%0d required %b %h %b %h %0d",
                   n, tx_valid, tx_data, wr_pulse, regs_flat, err_cnt, m_txv, m_txd, m_wr, model_flat(), m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_led_write();
    test_auto_inc();
    test_errors();
    test_read();
    test_simultaneous();
    test_gsr_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pif_regctl.md
# pif_regctl

Command decoder and register bank sitting directly downstream of the EFB I2C slave byte interface in the flasher design. Consumes the tagged byte stream the host writes (2-bit tag + 6-bit payload, tags `A_ADDR` / `D_ADDR` from pifdefs.v), keeps a register pointer across transactions, writes an internal bank of 6-bit registers, and serves read bytes back to the slave. Register 2 drives the LED mode consumed by the LEDR/LEDG flasher logic.

## Interface
- NREGS, 8, number of 6-bit registers (addresses 0..NREGS-1)
- ID_VAL, 6'h2A, read-only value of register 0
- LED_RST, 6'd0, reset value of register 2 (LED mode)
- CLK  in  1  system clock; all logic on rising edge
- GSRn  in  1  asynchronous active-low reset
- rx_data  in  8  byte received from I2C slave; [7:6] tag, [5:0] payload
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_start  in  1  one-cycle strobe on START / repeated START
- rx_stop  in  1  one-cycle strobe on STOP
- tx_req  in  1  one-cycle strobe, slave needs next read byte
- tx_data  out  8  read byte to slave
- tx_valid  out  1  one-cycle strobe, tx_data valid
- regs_flat  out  6*NREGS  register bank, reg n at [6n+5:6n]
- led_mode  out  6  copy of register 2
- wr_pulse  out  1  one-cycle strobe on every committed register write
- err_cnt  out  8  saturating count of malformed bytes

## Operation
- Reset: FSM=IDLE; ptr=0; ptr_valid=0; all registers 0 except reg0=ID_VAL, reg2=LED_RST; tx_data=8'h00; tx_valid=0; wr_pulse=0; err_cnt=0.
- FSM states: IDLE, ACTIVE.
  - IDLE: rx_start -> ACTIVE. rx_valid in IDLE ignored (no write, no error count). tx_req in IDLE still served.
  - ACTIVE: rx_stop -> IDLE; rx_start stays ACTIVE (repeated start). ptr and ptr_valid persist across STOP/START.
- Byte decode in ACTIVE on rx_valid:
  - tag == `A_ADDR`: ptr <= payload; ptr_valid <= 1.
  - tag == `D_ADDR`: if ptr_valid and ptr < NREGS and ptr != 0: reg[ptr] <= payload, wr_pulse=1. Then ptr <= ptr+1 (6-bit wrap, 63 -> 0) regardless of write success. If ptr_valid==0: no write, err_cnt++.
  - any other tag: ignored, err_cnt++.
  - ptr >= NREGS or ptr==0 on data: write dropped silently, ptr still increments.
- Read on tx_req: tx_data <= {`D_ADDR`, reg[ptr]} if ptr < NREGS, else 8'hFF; tx_valid=1; ptr <= ptr+1 (wrap). ptr_valid not required (reads ptr, default 0 -> ID).
- err_cnt saturates at 8'hFF.

## Timing
- Register write visible on regs_flat/led_mode and wr_pulse high exactly 1 cycle after rx_valid.
- tx_valid exactly 1 cycle after tx_req, high for 1 cycle; tx_data held until next tx_req.
- rx_valid and rx_stop same cycle: byte decoded first, then IDLE.
- rx_valid and tx_req same cycle: byte processed; read uses pre-cycle ptr and pre-write register value; ptr ends at (result of byte decode)+1 for D tags, or payload for A tags (address load wins, no read increment).
- Back-to-back rx_valid every cycle supported with no loss.
- GSRn low mid-transaction: immediate return to reset values, including in-flight tx_valid.

## Test plan
- Reset then tx_req -> tx_valid next cycle, tx_data={`D_ADDR`,6'h2A}; led_mode=0.
- START, {`A_ADDR`,6'd2}, {`D_ADDR`,6'd1}, STOP -> led_mode=1 one cycle after data strobe, wr_pulse single pulse, ptr=3.
- START, {`A_ADDR`,6'd6}, three D bytes 5,6,7 -> reg6=5, reg7=6, third dropped (ptr 8>=NREGS), ptr=9, err_cnt=0.
- After reset, START, {`D_ADDR`,6'd4} then byte 8'h00 and 8'hC0 -> no writes, err_cnt=3; 260 bad bytes -> err_cnt=8'hFF.
- Write ptr=2 via A byte, STOP, START, tx_req x2 -> tx_data reg2 then reg3, ptr=4; A_ADDR 63 + D byte -> dropped, ptr wraps to 0.
- GSRn pulse low between rx_valid and expected tx_valid -> all outputs at reset values, tx_valid stays 0.
